csr_req_arbiter: RTL and testbench
==================================

Name: csr_req_arbiter

Overview:
- Shares one accelerator CSR port between NumReq requesters (cores or DMA config agents).
- Round-robin grant with grant lock while a request is stalled.
- Tracks outstanding read transactions in an in-order ID FIFO so each read response returns to the requester that issued it.
- Sits between requester CSR ports and a CSR mux/demux or an accelerator CSR manager.

Parameters:
- NumReq, 2, number of requester ports (≥2).
- RegAddrWidth, 5, CSR address width.
- RegDataWidth, 32, CSR data width.
- MaxOutstanding, 4, depth of the read-response ID FIFO (power of two).
- IdWidth, $clog2(NumReq), width of the requester index (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_addr_i  in  NumReq×RegAddrWidth  per-requester CSR address.
- req_wr_data_i  in  NumReq×RegDataWidth  per-requester write data.
- req_wr_en_i  in  NumReq  1=write, 0=read.
- req_valid_i  in  NumReq  request valid.
- req_ready_o  out  NumReq  request accepted.
- req_rd_data_o  out  NumReq×RegDataWidth  read data, returned to the owner.
- req_rsp_valid_o  out  NumReq  response valid.
- req_rsp_ready_i  in  NumReq  response ready.
- acc_addr_o  out  RegAddrWidth  forwarded address.
- acc_wr_data_o  out  RegDataWidth  forwarded write data.
- acc_wr_en_o  out  1  forwarded write enable.
- acc_req_valid_o  out  1  forwarded request valid.
- acc_req_ready_i  in  1  accelerator accepts request.
- acc_rd_data_i  in  RegDataWidth  accelerator read data.
- acc_rsp_valid_i  in  1  accelerator response valid.
- acc_rsp_ready_o  out  1  response ready to accelerator.
- outstanding_o  out  $clog2(MaxOutstanding)+1  reads in flight.
- busy_o  out  1  outstanding_o != 0 or a lock is held.

Behaviour:
- Clocking and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- While rst_i is high, all outputs are 0: req_ready_o, req_rsp_valid_o, acc_req_valid_o, acc_rsp_ready_o, outstanding_o and busy_o. On reset: rr_q=0, lock_q=0, FIFO empty. Reset mid-transaction discards all in-flight IDs.
- Arbitration: when lock_q=0, grant is the first asserted req_valid_i searching from index rr_q upward, wrapping modulo NumReq. When lock_q=1, grant = grant_q.
- Request forwarding is combinational, zero added latency: acc_addr/wr_data/wr_en are taken from the granted requester. When nothing is granted, all acc_* request outputs are 0.
- Read admission: can_issue = wr_en | !fifo_full. Writes produce no response and are never blocked by FIFO state.
- acc_req_valid_o = req_valid_i[grant] & can_issue.
- req_ready_o[grant] = acc_req_ready_i & can_issue. All other req_ready_o bits are 0.
- Lock: set lock_q and grant_q when acc_req_valid_o=1 and acc_req_ready_i=0. Clear on handshake. Once locked, grant holds even if a higher-priority requester asserts valid.
- Handshake (acc_req_valid_o & acc_req_ready_i): rr_q <= (grant+1) mod NumReq. If it is a read, push grant into the ID FIFO.
- Full FIFO: a read is stalled with acc_req_valid_o=0 and no lock is taken. A pop in the same cycle does NOT admit the read; it is admitted the next cycle. This avoids a response→request combinational path.
- Response routing: head = FIFO head ID.
  - req_rsp_valid_o[head] = acc_rsp_valid_i & !fifo_empty.
  - req_rd_data_o[head] = acc_rd_data_i; non-head data outputs are 0.
  - acc_rsp_ready_o = req_rsp_ready_i[head] & !fifo_empty.
  - Pop on acc_rsp_valid_i & acc_rsp_ready_o.
- Empty FIFO: acc_rsp_valid_i is ignored, acc_rsp_ready_o=0. This is an accelerator protocol violation; the assertion fires in simulation.
- Simultaneous push and pop with the FIFO not full: both occur and the count is unchanged.
- Responses are strictly in issue order; the accelerator is required to respond in order.
- outstanding_o is registered: the FIFO count after the current cycle's push/pop.

Decomposition:
- Package csr_arb_pkg holds:
  - default width constants (RegAddrWidth, RegDataWidth);
  - csr_req_t struct {addr, wr_data, wr_en};
  - function rr_pick(valid, ptr) returning the grant index.
- Sub-module csr_rsp_id_fifo:
  - synchronous FIFO of IdWidth×MaxOutstanding;
  - push/pop/full/empty/count ports; clk_i/rst_i;
  - no fall-through.

Test Plan:
- Reset, then both req_valid_i=11 with writes → req 0 granted cycle 1, req 1 granted cycle 2, rr_q alternates; no FIFO push.
- Req 0 read addr 3 with acc_req_ready_i held 0 for 3 cycles, req 1 asserts meanwhile → grant stays 0 (lock); on ready, rr_q=1 and req 1 is served next.
- Req 1 read, then req 0 read; accelerator returns 0xAAAA then 0xBBBB → req_rsp_valid_o[1] with 0xAAAA first, then [0] with 0xBBBB; outstanding_o goes 1,2,1,0.
- Issue 4 reads without responses → outstanding_o=4; 5th read gets acc_req_valid_o=0. Pop one response that cycle → 5th read is issued the following cycle.
- Head requester holds req_rsp_ready_i=0 while acc_rsp_valid_i=1 → acc_rsp_ready_o=0, FIFO unchanged; a write from the other requester is still issued.
- Assert rst_i with 2 reads outstanding → all outputs 0 next cycle, outstanding_o=0; a late acc_rsp_valid_i after reset is ignored.

Source files
------------

// File: rtl/csr_arb_pkg.sv
// Shared constants, request struct and round-robin pick helper for the CSR
// request arbiter.
package csr_arb_pkg;

    localparam int RegAddrWidth = 5;
    localparam int RegDataWidth = 32;
    localparam int MaxReq       = 16;
    localparam int MaxIdW       = 4;

    typedef struct packed {
        logic [RegAddrWidth-1:0] addr;
        logic [RegDataWidth-1:0] wr_data;
        logic                    wr_en;
    } csr_req_t;

    // First set bit of valid at or above ptr, wrapping modulo n; returns ptr
    // when nothing is valid (caller qualifies with |valid).
    function automatic int rr_pick(input logic [MaxReq-1:0] valid,
                                   input int ptr, input int n);
        int idx;
        int pick;
        pick = ptr;
        for (int i = MaxReq - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = ptr + i;
                if (idx >= n) idx = idx - n;
                if (valid[idx[MaxIdW-1:0]]) pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/csr_rsp_id_fifo.sv
// In-order FIFO of requester IDs for reads awaiting a response. Registered
// head, no fall-through: a pushed entry is visible the cycle after the push.
module csr_rsp_id_fifo #(
    parameter int Width = 1,
    parameter int Depth = 4,
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int CntW = $clog2(Depth) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/csr_req_arbiter.sv
// Round-robin arbiter sharing one accelerator CSR port between NumReq
// requesters, with grant lock on stall and in-order read response routing.
module csr_req_arbiter #(
    parameter int NumReq         = 2,
    parameter int RegAddrWidth   = csr_arb_pkg::RegAddrWidth,
    parameter int RegDataWidth   = csr_arb_pkg::RegDataWidth,
    parameter int MaxOutstanding = 4,
    parameter int IdWidth        = $clog2(NumReq)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NumReq-1:0][RegAddrWidth-1:0]     req_addr_i,
    input  logic [NumReq-1:0][RegDataWidth-1:0]     req_wr_data_i,
    input  logic [NumReq-1:0]                       req_wr_en_i,
    input  logic [NumReq-1:0]                       req_valid_i,
    output logic [NumReq-1:0]                       req_ready_o,
    output logic [NumReq-1:0][RegDataWidth-1:0]     req_rd_data_o,
    output logic [NumReq-1:0]                       req_rsp_valid_o,
    input  logic [NumReq-1:0]                       req_rsp_ready_i,
    output logic [RegAddrWidth-1:0]                 acc_addr_o,
    output logic [RegDataWidth-1:0]                 acc_wr_data_o,
    output logic                                    acc_wr_en_o,
    output logic                                    acc_req_valid_o,
    input  logic                                    acc_req_ready_i,
    input  logic [RegDataWidth-1:0]                 acc_rd_data_i,
    input  logic                                    acc_rsp_valid_i,
    output logic                                    acc_rsp_ready_o,
    output logic [$clog2(MaxOutstanding):0]         outstanding_o,
    output logic                                    busy_o
);
    import csr_arb_pkg::*;

    logic [IdWidth-1:0] rr_q, rr_d, grant_q, grant_d, grant, grant_pick;
    logic               lock_q, lock_d;
    logic               gnt_vld, can_issue, hs, push, pop;
    logic [IdWidth-1:0] head;
    logic               fifo_full, fifo_empty;
    logic [$clog2(MaxOutstanding):0] fifo_count;

    assign grant_pick = IdWidth'(rr_pick(MaxReq'(req_valid_i), int'(rr_q), NumReq));
    assign grant      = lock_q ? grant_q : grant_pick;
    assign gnt_vld    = ~rst_i & (lock_q | (|req_valid_i));

    // Full FIFO is judged on registered state so a same-cycle pop never
    // creates a response-to-request combinational path.
    assign can_issue       = req_wr_en_i[grant] | ~fifo_full;
    assign acc_req_valid_o = gnt_vld & req_valid_i[grant] & can_issue;
    assign acc_addr_o      = gnt_vld ? req_addr_i[grant]    : '0;
    assign acc_wr_data_o   = gnt_vld ? req_wr_data_i[grant] : '0;
    assign acc_wr_en_o     = gnt_vld & req_wr_en_i[grant];
    assign hs              = acc_req_valid_o & acc_req_ready_i;
    assign push            = hs & ~req_wr_en_i[grant];

    always_comb begin
        req_ready_o = '0;
        if (gnt_vld) req_ready_o[grant] = acc_req_ready_i & can_issue;
    end

    always_comb begin
        rr_d    = rr_q;
        lock_d  = lock_q;
        grant_d = grant_q;
        if (hs) begin
            rr_d   = (grant == IdWidth'(NumReq - 1)) ? '0 : grant + 1'b1;
            lock_d = 1'b0;
        end else if (acc_req_valid_o) begin
            lock_d  = 1'b1;
            grant_d = grant;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q    <= '0;
            lock_q  <= 1'b0;
            grant_q <= '0;
        end else begin
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        req_rsp_valid_o = '0;
        req_rd_data_o   = '0;
        acc_rsp_ready_o = 1'b0;
        if (~rst_i & ~fifo_empty) begin
            req_rsp_valid_o[head] = acc_rsp_valid_i;
            req_rd_data_o[head]   = acc_rd_data_i;
            acc_rsp_ready_o       = req_rsp_ready_i[head];
        end
    end

    assign pop = acc_rsp_valid_i & acc_rsp_ready_o;

    csr_rsp_id_fifo #(
        .Width (IdWidth),
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (grant),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign outstanding_o = rst_i ? '0 : fifo_count;
    assign busy_o        = ~rst_i & ((fifo_count != '0) | lock_q);

    // A response with nothing outstanding is an accelerator protocol error.
    rsp_without_read_a: assert property (@(posedge clk_i) disable iff (rst_i)
        acc_rsp_valid_i |-> ~fifo_empty);

endmodule

// File: tb/tb_csr_req_arbiter.sv
// Directed plus randomized bench for csr_req_arbiter; a queue of expected
// requester IDs checks read response routing and ordering.
module tb_csr_req_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0][4:0]  req_addr;
    logic [1:0][31:0] req_wr_data;
    logic [1:0]       req_wr_en, req_valid, req_ready, req_rsp_valid, req_rsp_ready;
    logic [1:0][31:0] req_rd_data;
    logic [4:0]       acc_addr;
    logic [31:0]      acc_wr_data, acc_rd_data;
    logic             acc_wr_en, acc_req_valid, acc_req_ready, acc_rsp_valid, acc_rsp_ready;
    logic [2:0]       outstanding;
    logic             busy;

    logic [0:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    csr_req_arbiter dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_addr_i      (req_addr),
        .req_wr_data_i   (req_wr_data),
        .req_wr_en_i     (req_wr_en),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_rd_data_o   (req_rd_data),
        .req_rsp_valid_o (req_rsp_valid),
        .req_rsp_ready_i (req_rsp_ready),
        .acc_addr_o      (acc_addr),
        .acc_wr_data_o   (acc_wr_data),
        .acc_wr_en_o     (acc_wr_en),
        .acc_req_valid_o (acc_req_valid),
        .acc_req_ready_i (acc_req_ready),
        .acc_rd_data_i   (acc_rd_data),
        .acc_rsp_valid_i (acc_rsp_valid),
        .acc_rsp_ready_o (acc_rsp_ready),
        .outstanding_o   (outstanding),
        .busy_o          (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // One response beat with both requesters ready; destination comes from exp_q.
    task automatic rsp_beat(input logic [31:0] d, input logic [2:0] exp_out);
        logic [0:0] e;
        acc_rsp_valid = 1'b1;
        acc_rd_data   = d;
        req_rsp_ready = 2'b11;
        settle();
        check_eq("rsp_outstanding", 64'(outstanding), 64'(exp_out));
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_underflow: got response 0x%0h expected none", d);
        end else begin
            e = exp_q.pop_front();
            check_eq("rsp_valid", 64'(req_rsp_valid), 64'(2'b01 << e));
            check_eq("rsp_data", 64'(req_rd_data[e]), 64'(d));
            check_eq("rsp_other_data", 64'(req_rd_data[~e]), 64'd0);
            check_eq("acc_rsp_ready", 64'(acc_rsp_ready), 64'd1);
        end
        tick();
        acc_rsp_valid = 1'b0;
        req_rsp_ready = 2'b00;
    endtask

    initial begin
        logic [0:0]  r;
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;

        rst = 1'b1;
        req_addr = '0;
        req_wr_data = '0;
        req_wr_en = 2'b11;
        req_valid = 2'b11;
        req_rsp_ready = 2'b00;
        acc_req_ready = 1'b1;
        acc_rd_data = '0;
        acc_rsp_valid = 1'b0;
        req_addr[0] = 5'd1;
        req_addr[1] = 5'd2;
        req_wr_data[0] = 32'h1111_0000;
        req_wr_data[1] = 32'h2222_0000;

        // Reset holds every output low even with requests pending.
        tick();
        tick();
        settle();
        check_eq("rst_acc_valid", 64'(acc_req_valid), 64'd0);
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_outstanding", 64'(outstanding), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_acc_addr", 64'(acc_addr), 64'd0);
        check_eq("rst_acc_rsp_ready", 64'(acc_rsp_ready), 64'd0);
        tick();
        rst = 1'b0;

        // Two competing writers alternate.
        settle();
        check_eq("rr_c1_valid", 64'(acc_req_valid), 64'd1);
        check_eq("rr_c1_ready", 64'(req_ready), 64'b01);
        check_eq("rr_c1_addr", 64'(acc_addr), 64'd1);
        check_eq("rr_c1_data", 64'(acc_wr_data), 64'h1111_0000);
        check_eq("rr_c1_wr", 64'(acc_wr_en), 64'd1);
        tick();
        settle();
        check_eq("rr_c2_ready", 64'(req_ready), 64'b10);
        check_eq("rr_c2_addr", 64'(acc_addr), 64'd2);
        tick();
        settle();
        check_eq("rr_c3_ready", 64'(req_ready), 64'b01);
        check_eq("rr_no_push", 64'(outstanding), 64'd0);
        tick();

        // Stalled read from req 0 locks the grant against req 1.
        req_valid = 2'b01;
        req_wr_en = 2'b00;
        req_addr[0] = 5'd3;
        acc_req_ready = 1'b0;
        settle();
        check_eq("lock_valid", 64'(acc_req_valid), 64'd1);
        check_eq("lock_addr0", 64'(acc_addr), 64'd3);
        check_eq("lock_wr", 64'(acc_wr_en), 64'd0);
        check_eq("lock_ready0", 64'(req_ready), 64'd0);
        tick();
        req_valid = 2'b11;
        req_wr_en = 2'b10;
        req_addr[1] = 5'd9;
        settle();
        check_eq("lock_addr1", 64'(acc_addr), 64'd3);
        check_eq("lock_ready1", 64'(req_ready), 64'd0);
        check_eq("lock_busy", 64'(busy), 64'd1);
        tick();
        settle();
        check_eq("lock_addr2", 64'(acc_addr), 64'd3);
        tick();
        acc_req_ready = 1'b1;
        settle();
        check_eq("lock_release_ready", 64'(req_ready), 64'b01);
        check_eq("lock_release_addr", 64'(acc_addr), 64'd3);
        exp_q.push_back(1'b0);
        tick();
        req_wr_en = 2'b11;
        settle();
        check_eq("after_lock_ready", 64'(req_ready), 64'b10);
        check_eq("after_lock_addr", 64'(acc_addr), 64'd9);
        check_eq("after_lock_out", 64'(outstanding), 64'd1);
        tick();
        req_valid = 2'b00;
        rsp_beat(32'h0000_1234, 3'd1);

        // Two reads from different requesters return in issue order.
        req_wr_en = 2'b00;
        req_valid = 2'b10;
        req_addr[1] = 5'd5;
        settle();
        check_eq("ord_ready1", 64'(req_ready), 64'b10);
        check_eq("ord_addr1", 64'(acc_addr), 64'd5);
        exp_q.push_back(1'b1);
        tick();
        req_valid = 2'b01;
        req_addr[0] = 5'd6;
        settle();
        check_eq("ord_ready0", 64'(req_ready), 64'b01);
        check_eq("ord_out1", 64'(outstanding), 64'd1);
        exp_q.push_back(1'b0);
        tick();
        req_valid = 2'b00;
        settle();
        check_eq("ord_out2", 64'(outstanding), 64'd2);
        tick();
        rsp_beat(32'h0000_AAAA, 3'd2);
        rsp_beat(32'h0000_BBBB, 3'd1);
        settle();
        check_eq("ord_out0", 64'(outstanding), 64'd0);
        tick();

        // Fill the ID FIFO; a same-cycle pop does not admit the stalled read.
        req_valid = 2'b01;
        req_addr[0] = 5'd7;
        for (int k = 0; k < 4; k++) begin
            settle();
            check_eq("fill_ready", 64'(req_ready), 64'b01);
            check_eq("fill_out", 64'(outstanding), 64'(k));
            exp_q.push_back(1'b0);
            tick();
        end
        acc_rsp_valid = 1'b1;
        acc_rd_data = 32'h0000_0055;
        req_rsp_ready = 2'b11;
        settle();
        check_eq("full_acc_valid", 64'(acc_req_valid), 64'd0);
        check_eq("full_req_ready", 64'(req_ready), 64'd0);
        check_eq("full_out", 64'(outstanding), 64'd4);
        check_eq("full_pop_rdy", 64'(acc_rsp_ready), 64'd1);
        check_eq("full_pop_valid", 64'(req_rsp_valid), 64'b01);
        void'(exp_q.pop_front());
        tick();
        acc_rsp_valid = 1'b0;
        req_rsp_ready = 2'b00;
        settle();
        check_eq("refill_valid", 64'(acc_req_valid), 64'd1);
        check_eq("refill_ready", 64'(req_ready), 64'b01);
        check_eq("refill_out", 64'(outstanding), 64'd3);
        exp_q.push_back(1'b0);
        tick();
        req_valid = 2'b00;
        settle();
        check_eq("refill_out4", 64'(outstanding), 64'd4);
        tick();
        for (int k = 4; k > 0; k--) rsp_beat($urandom_range(0, 32'hFFFF), 3'(k));

        // Head requester back-pressures; the other requester's write still goes.
        req_valid = 2'b10;
        req_addr[1] = 5'd8;
        settle();
        check_eq("bp_read_ready", 64'(req_ready), 64'b10);
        exp_q.push_back(1'b1);
        tick();
        req_valid = 2'b01;
        req_wr_en = 2'b01;
        req_addr[0] = 5'd10;
        acc_rsp_valid = 1'b1;
        acc_rd_data = 32'h0000_00CC;
        req_rsp_ready = 2'b01;
        settle();
        check_eq("bp_acc_rsp_ready", 64'(acc_rsp_ready), 64'd0);
        check_eq("bp_rsp_valid", 64'(req_rsp_valid), 64'b10);
        check_eq("bp_wr_ready", 64'(req_ready), 64'b01);
        check_eq("bp_wr_en", 64'(acc_wr_en), 64'd1);
        check_eq("bp_out", 64'(outstanding), 64'd1);
        tick();
        req_valid = 2'b00;
        settle();
        check_eq("bp_hold_out", 64'(outstanding), 64'd1);
        tick();
        rsp_beat(32'h0000_00CC, 3'd1);

        // Reset with two reads in flight discards them.
        req_wr_en = 2'b00;
        req_valid = 2'b11;
        settle();
        check_eq("rst2_first", 64'(req_ready), 64'b10);
        tick();
        settle();
        check_eq("rst2_second", 64'(req_ready), 64'b01);
        tick();
        req_valid = 2'b00;
        settle();
        check_eq("rst2_out2", 64'(outstanding), 64'd2);
        tick();
        rst = 1'b1;
        req_valid = 2'b11;
        acc_rsp_valid = 1'b1;
        acc_rd_data = 32'hDEAD_BEEF;
        req_rsp_ready = 2'b11;
        settle();
        check_eq("rst2_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst2_acc_valid", 64'(acc_req_valid), 64'd0);
        check_eq("rst2_acc_rsp_ready", 64'(acc_rsp_ready), 64'd0);
        check_eq("rst2_rsp_valid", 64'(req_rsp_valid), 64'd0);
        check_eq("rst2_rd_data", 64'(req_rd_data), 64'd0);
        check_eq("rst2_out", 64'(outstanding), 64'd0);
        check_eq("rst2_busy", 64'(busy), 64'd0);
        tick();
        settle();
        check_eq("rst2_late_rsp", 64'(req_rsp_valid), 64'd0);
        tick();
        rst = 1'b0;
        acc_rsp_valid = 1'b0;
        req_rsp_ready = 2'b00;
        req_valid = 2'b00;
        settle();
        check_eq("post_rst_out", 64'(outstanding), 64'd0);
        check_eq("post_rst_busy", 64'(busy), 64'd0);
        tick();

        // Random single-requester traffic.
        for (int k = 0; k < 24; k++) begin
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = 5'($urandom_range(0, 31));
            d = $urandom();
            req_addr[r] = a;
            req_wr_data[r] = d;
            req_wr_en[r] = w;
            req_valid = 2'b01 << r;
            settle();
            check_eq("rnd_ready", 64'(req_ready), 64'(2'b01 << r));
            check_eq("rnd_addr", 64'(acc_addr), 64'(a));
            check_eq("rnd_wr", 64'(acc_wr_en), 64'(w));
            if (w) check_eq("rnd_wdata", 64'(acc_wr_data), 64'(d));
            if (!w) exp_q.push_back(r);
            tick();
            req_valid = 2'b00;
            if (!w) rsp_beat($urandom(), 3'd1);
        end

        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
